div_result_buffer: RTL and testbench

- Downstream companion to the signed pipelined divider (WIDTH=50, 16 stages).
- The divider has no backpressure: it emits a fixed-latency data_valid/quotient/div_by_zero stream.
- This block captures that stream into a show-ahead FIFO and presents it on a valid/ready interface.
- It owns a credit counter that gates the divider's start, so every operation issued into the pipeline has a guaranteed buffer slot.

---
 rtl/div_result_buffer.sv | 136 +++++++++++++
 tb/tb_div_result_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_buffer.sv
// Result buffer behind the pipelined divider: show-ahead FIFO plus
// a credit counter that gates divider starts so no result is lost.
module div_result_buffer #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_req,
  output logic             issue_grant,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_quotient,
  input  logic             in_div_by_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic             out_div_by_zero,
  output logic [AW:0]      count,
  output logic [AW:0]      credits,
  output logic             overflow_err
);

  typedef struct packed {
    logic             dz;
    logic [WIDTH-1:0] q;
  } entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [AW:0]   cred_q;
  logic [AW:0]   cred_d;
  logic          ovf_q;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic grant;

  assign full  = (cnt_q == FULL);
  assign pop   = out_valid && out_ready;
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && full && !pop;
  // Grant looks only at registered credits: no pop-to-grant path.
  assign grant = issue_req && (cred_q != '0);

  assign issue_grant     = grant;
  assign out_valid       = (cnt_q != '0);
  assign out_quotient    = mem[rd_ptr].q;
  assign out_div_by_zero = mem[rd_ptr].dz;
  assign count           = cnt_q;
  assign credits         = cred_q;
  assign overflow_err    = ovf_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{dz: in_div_by_zero, q: in_quotient};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    cred_d = cred_q;
    unique case ({grant, pop})
      2'b10:   cred_d = cred_q - ONE;
      2'b01:   cred_d = cred_q + ONE;
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      cred_q <= FULL;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cred_q <= cred_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Operations between grant and arrival; only feeds the checks below.
  logic signed [AW+3:0] in_flight;
  logic signed [AW+3:0] inv_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      in_flight <= in_flight
                 + $signed({{(AW+3){1'b0}}, grant})
                 - $signed({{(AW+3){1'b0}}, in_valid});
    end
  end

  assign inv_sum = $signed({3'b000, cred_q})
                 + $signed({3'b000, cnt_q})
                 + in_flight;

  a_cred_max: assert property (
    @(posedge clk) disable iff (!rst_n)
    cred_q <= FULL
  );

  a_slots: assert property (
    @(posedge clk) disable iff (!rst_n || ovf_q)
    inv_sum == $signed((AW+4)'(DEPTH))
  );

endmodule

// File: tb/tb_div_result_buffer.sv
// Bench for div_result_buffer: divider emulated as a 16-cycle delay
// line, buffer modelled as a queue of entries plus a credit integer.
module tb_div_result_buffer;

  localparam int W   = 50;
  localparam int D   = 16;
  localparam int LAT = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_req = 1'b0;
  logic          issue_grant;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_quotient = '0;
  logic          in_div_by_zero = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_quotient;
  logic          out_div_by_zero;
  logic [AW:0]   count;
  logic [AW:0]   credits;
  logic          overflow_err;

  always #5 clk = ~clk;

  div_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_req       (issue_req),
    .issue_grant     (issue_grant),
    .in_valid        (in_valid),
    .in_quotient     (in_quotient),
    .in_div_by_zero  (in_div_by_zero),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_quotient    (out_quotient),
    .out_div_by_zero (out_div_by_zero),
    .count           (count),
    .credits         (credits),
    .overflow_err    (overflow_err)
  );

  // Model: entries are {div_by_zero, quotient}.
  logic [W:0] mq[$];
  int         m_cred;
  bit         m_ovf;
  bit         pv [LAT];
  logic [W:0] pd [LAT];
  bit         fv;
  logic [W:0] fd;
  logic [W:0] next_e;
  logic [W:0] saved;
  int         n_tests;
  int         n_fail;
  int         grants;
  int         guard;

  function automatic logic [W:0] rnd_ent();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {($urandom % 8 == 0), r[W-1:0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_model();
    mq.delete();
    m_cred = D;
    m_ovf  = 1'b0;
    fv     = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    issue_req = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rst_n     = 1'b0;
    clr_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input bit req, input bit rdy);
    bit         g;
    bit         pop;
    bit         push;
    bit         iv;
    logic [W:0] id;
    @(negedge clk);
    iv = pv[LAT-1] | fv;
    id = fv ? fd : pd[LAT-1];
    issue_req      = req;
    out_ready      = rdy;
    in_valid       = iv;
    in_quotient    = id[W-1:0];
    in_div_by_zero = id[W];
    #1;
    g = req && (m_cred != 0);
    chk("grant", issue_grant, g);
    if (issue_grant) grants++;
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_q", out_quotient, mq[0][W-1:0]);
      chk("out_dz", out_div_by_zero, mq[0][W]);
    end
    pop  = (mq.size() != 0) && rdy;
    push = iv && (mq.size() != D || pop);
    if (iv && mq.size() == D && !pop) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(id);
    m_cred = m_cred + int'(pop) - int'(g);
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = g;
    pd[0] = next_e;
    if (g) next_e = rnd_ent();
    fv = 1'b0;
    chk("count", count, mq.size());
    chk("credits", credits, m_cred);
    chk("ovf", overflow_err, m_ovf);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    grants  = 0;
    next_e  = rnd_ent();
    clr_model();
    #12;
    chk("rst_count", count, 0);
    chk("rst_credits", credits, D);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow_err, 0);
    do_reset();

    // Single operation with quotient -7.
    next_e = {1'b0, 50'h3FFFFFFFFFFF9};
    cyc(1'b1, 1'b0);
    chk("t1_cred15", credits, 15);
    repeat (15) cyc(1'b0, 1'b0);
    chk("t1_empty", count, 0);
    cyc(1'b0, 1'b0);
    chk("t1_count1", count, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_q", out_quotient, 50'h3FFFFFFFFFFF9);
    cyc(1'b0, 1'b1);
    chk("t1_popcnt", count, 0);
    chk("t1_popcred", credits, 16);

    // Fill with the consumer stalled.
    grants = 0;
    repeat (20) cyc(1'b1, 1'b0);
    chk("t2_grants", grants, 16);
    repeat (20) cyc(1'b0, 1'b0);
    chk("t2_count", count, 16);
    chk("t2_cred", credits, 0);
    chk("t2_ovf", overflow_err, 0);
    // No grant at zero credits even with a pop this cycle.
    cyc(1'b1, 1'b1);
    chk("t2_cred_pop", credits, 1);
    cyc(1'b1, 1'b0);
    repeat (17) cyc(1'b0, 1'b0);
    chk("t2_refull", count, 16);

    // Full: forced arrival together with a pop.
    fv = 1'b1;
    fd = rnd_ent();
    saved = fd;
    cyc(1'b0, 1'b1);
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow_err, 0);

    // Full, stalled: forced arrival is dropped.
    saved[W] = saved[W];
    fd = mq[0];
    fv = 1'b1;
    fd = {1'b0, 50'd5};
    cyc(1'b0, 1'b0);
    chk("t4_ovf", overflow_err, 1);
    chk("t4_count", count, 16);
    cyc(1'b0, 1'b0);
    chk("t4_sticky", overflow_err, 1);
    repeat (15) cyc(1'b0, 1'b1);
    chk("t3_tail_q", out_quotient, saved[W-1:0]);
    chk("t3_tail_dz", out_div_by_zero, saved[W]);
    chk("t3_tail_cnt", count, 1);
    do_reset();

    // Div-by-zero flag carried through.
    next_e = {1'b1, 50'd0};
    cyc(1'b1, 1'b0);
    next_e = {1'b0, 50'd123};
    cyc(1'b1, 1'b0);
    repeat (16) cyc(1'b0, 1'b0);
    chk("t5_dz", out_div_by_zero, 1);
    chk("t5_q0", out_quotient, 0);
    cyc(1'b0, 1'b1);
    chk("t5_dz_next", out_div_by_zero, 0);
    chk("t5_q_next", out_quotient, 123);
    cyc(1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i < 200) cyc(($urandom % 4) != 0, ($urandom % 3) == 0);
      else cyc(($urandom % 4) != 0, ($urandom % 3) != 0);
    end
    repeat (40) cyc(1'b0, 1'b1);
    chk("rnd_drain_cnt", count, 0);
    chk("rnd_drain_cred", credits, 16);

    // Asynchronous reset between edges, mid-stream.
    repeat (13) cyc(1'b1, 1'b0);
    guard = 0;
    while (mq.size() != 9 && guard < 40) begin
      cyc(1'b0, 1'b0);
      guard++;
    end
    chk("t6_guard", guard < 40, 1);
    chk("t6_pre_cnt", count, 9);
    chk("t6_pre_cred", credits, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cnt", count, 0);
    chk("t6_cred", credits, 16);
    chk("t6_valid", out_valid, 0);
    chk("t6_ovf", overflow_err, 0);
    issue_req = 1'b0;
    in_valid  = 1'b0;
    clr_model();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b1);
    chk("t6_after", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
